// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO.
// Provides the count-width function and a packed status bundle.
package fifo_pkg;

    // Occupancy runs 0..2**aw inclusive, so it needs one bit more
    // than the pointers.
    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register-file storage: DWIDTH x 2**AWIDTH words.
// Ports: clk, w_en/w_addr/w_data (sync write), r_addr/r_data (async read).
module fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [AWIDTH-1:0] w_addr,
    input  logic [DWIDTH-1:0] w_data,
    input  logic [AWIDTH-1:0] r_addr,
    output logic [DWIDTH-1:0] r_data
);

    localparam int DEPTH = 2 ** AWIDTH;

    // Storage is deliberately not reset.
    logic [DWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (w_en) begin
            mem_q[w_addr] <= w_data;
        end
    end

    assign r_data = mem_q[r_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO with count, status and sticky error flags.
// Ports: clk, reset (sync, active-high), push/wdata, pop/rdata, clr_err,
//        full, empty, almost_full, count, overflow, underflow.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DWIDTH   = 8,
    parameter int AWIDTH   = 3,
    parameter int AFULL_TH = 2 ** AWIDTH - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              pop,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    localparam int CW = cnt_width(AWIDTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(2 ** AWIDTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [AWIDTH-1:0] wptr_q, wptr_d;
    logic [AWIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              push_ok, pop_ok;
    fifo_status_t      st;

    // Status is decoded from registered state only, never from inputs.
    always_comb begin
        st             = '0;
        st.full        = (cnt_q == DEPTH_C);
        st.empty       = (cnt_q == '0);
        st.almost_full = (cnt_q >= AFULL_C);
        st.overflow    = ovf_q;
        st.underflow   = unf_q;
    end

    // A full FIFO still takes a push when a pop frees a slot this cycle.
    assign pop_ok  = pop & ~st.empty;
    assign push_ok = push & (~st.full | pop_ok);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;

        if (push_ok) begin
            wptr_d = wptr_q + AWIDTH'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + AWIDTH'(1);
        end

        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - CW'(1);
        end

        // Clear first so a same-cycle error wins.
        if (clr_err) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (pop && !pop_ok) begin
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Reset must also block the memory write, otherwise the
    // discarded push would still land in storage.
    fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk    (clk),
        .w_en   (push_ok & ~reset),
        .w_addr (wptr_q),
        .w_data (wdata),
        .r_addr (rptr_q),
        .r_data (rdata)
    );

    assign full        = st.full;
    assign empty       = st.empty;
    assign almost_full = st.almost_full;
    assign overflow    = st.overflow;
    assign underflow   = st.underflow;
    assign count       = cnt_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DWIDTH=8, AWIDTH=3, AFULL_TH=7).
// Stimulus fills an expected-data queue; a monitor checks each pop.
module tb_sync_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic [7:0] wdata;
    logic       pop;
    logic [7:0] rdata;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    sync_fifo #(
        .DWIDTH   (8),
        .AWIDTH   (3),
        .AFULL_TH (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .wdata       (wdata),
        .pop         (pop),
        .rdata       (rdata),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk;
    int         n_fail;
    logic [7:0] exp_q[$];
    int         mcount;
    logic       movf;
    logic       munf;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT accepts a pop, the head must match.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && pop && !empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL pop_data: got 0x%0h, expected none @%0t",
                         rdata, $time);
            end else begin
                e = exp_q.pop_front();
                check("pop_data", int'(rdata), int'(e));
            end
        end
    end

    // One clock of stimulus; called at posedge+1, returns at posedge+1.
    task automatic step(input logic p, input logic [7:0] d,
                        input logic q, input logic c, input logic r);
        bit pok;
        bit wok;
        push    = p;
        wdata   = d;
        pop     = q;
        clr_err = c;
        reset   = r;
        pok = q && (mcount != 0);
        wok = p && ((mcount != 8) || pok);
        if (r) begin
            mcount = 0;
            movf   = 1'b0;
            munf   = 1'b0;
        end else begin
            if (wok) exp_q.push_back(d);
            if (wok && !pok) mcount++;
            else if (pok && !wok) mcount--;
            if (c) begin
                movf = 1'b0;
                munf = 1'b0;
            end
            if (p && !wok) movf = 1'b1;
            if (q && !pok) munf = 1'b1;
        end
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b0;
        if (r) exp_q.delete();
        check("count", int'(count), mcount);
        check("full", int'(full), int'(mcount == 8));
        check("empty", int'(empty), int'(mcount == 0));
        check("almost_full", int'(almost_full), int'(mcount >= 7));
        check("overflow", int'(overflow), int'(movf));
        check("underflow", int'(underflow), int'(munf));
        if (mcount > 0 && exp_q.size() > 0)
            check("head", int'(rdata), int'(exp_q[0]));
    endtask

    initial begin
        logic [7:0] v;
        n_chk   = 0;
        n_fail  = 0;
        mcount  = 0;
        movf    = 1'b0;
        munf    = 1'b0;
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        wdata   = 8'h00;
        clr_err = 1'b0;
        @(posedge clk);
        #1;

        // Reset then idle.
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);

        // Fill 0x11..0x88, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 8'h11);
            step(1, v, 0, 0, 0);
        end
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

        // Overflow on full, clear, contents intact.
        for (int i = 1; i <= 8; i++) begin
            v = 8'(8'hA0 + i);
            step(1, v, 0, 0, 0);
        end
        step(1, 8'h99, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

        // Push+pop on full and pointer wrap.
        for (int i = 1; i <= 8; i++) begin
            v = 8'(8'hC0 + i);
            step(1, v, 0, 0, 0);
        end
        step(1, 8'hAA, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Push+pop on empty: underflow, push still lands.
        step(1, 8'h5A, 1, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        // Error set wins over a same-cycle clear.
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'h00, 0, 1, 0);

        // Reset with push discards everything.
        step(1, 8'h01, 0, 0, 0);
        step(1, 8'h02, 0, 0, 0);
        step(1, 8'h03, 0, 0, 0);
        step(1, 8'h04, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised single-clock FIFO built around a dual-port register-file memory; successor to the plain 8-bit addressable RAM.
- Adds write/read pointer management, full/empty/almost-full status, an occupancy count and sticky overflow/underflow error flags.
- Sits between the UART RX/TX byte paths and the counter/command logic as the standard elastic buffer.
- Read data is first-word-fall-through (FWFT): the head entry is always visible on rdata.

Parameters:
- DWIDTH, 8, data word width in bits.
- AWIDTH, 3, address width; depth DEPTH = 2**AWIDTH entries.
- AFULL_TH, 2**AWIDTH-1, almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- push, input, 1, write request; accepted on a clock edge per the rules below.
- wdata, input, DWIDTH, data written on an accepted push.
- pop, input, 1, read request; advances the head on an accepted pop.
- rdata, output, DWIDTH, current head entry (FWFT, combinational from memory).
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AFULL_TH.
- count, output, AWIDTH+1, current occupancy, 0..DEPTH.
- overflow, output, 1, sticky: a push was rejected.
- underflow, output, 1, sticky: a pop was rejected.
- clr_err, input, 1, clears overflow and underflow.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (synchronous, reset=1 at a posedge):
  - wptr=0, rptr=0, count=0; empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not reset.
  - Reset overrides push, pop and clr_err in the same cycle.
  - Reset mid-operation discards all stored entries.
- Pointers: AWIDTH bits each, wrapping modulo DEPTH (DEPTH-1 -> 0). count is a separate AWIDTH+1-bit register.
- Acceptance:
  - push_ok = push & (~full | pop_ok).
  - pop_ok = pop & ~empty.
- Accepted push: mem[wptr] <= wdata; wptr <= wptr+1.
- Accepted pop: rptr <= rptr+1.
- count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both or neither: unchanged.
- Simultaneous push+pop:
  - Full: both accepted; count stays DEPTH; full stays 1.
  - Empty: pop rejected (underflow set); push accepted; count -> 1.
  - Neither full nor empty: both accepted; count unchanged.
- Rejected push (push & full & ~pop): memory and pointers unchanged; overflow <= 1.
- Rejected pop (pop & empty): pointers unchanged; underflow <= 1.
- clr_err:
  - Clears both flags next cycle.
  - If a new error occurs in the same cycle, the set wins (flag = 1).
- Latency:
  - Written data appears on rdata the cycle after push when the FIFO was empty; empty falls the same edge.
  - After an accepted pop, the next entry is on rdata the following cycle.
- rdata = mem[rptr], combinational. Its value while empty=1 is don't-care; the bench must not check it.
- full, empty and almost_full are decoded from the count register only (registered-state decode, no input paths).
- No state machine beyond the pointer/count registers; status outputs are pure functions of count.

Decomposition:
- Package fifo_pkg holds:
  - A function computing count width from AWIDTH.
  - typedef fifo_status_t (packed struct: full, empty, almost_full, overflow, underflow), for the bench and parent logic.
- Sub-module fifo_mem:
  - Parametrised DWIDTH x 2**AWIDTH storage.
  - Synchronous write on w_en, asynchronous read.
- sync_fifo instantiates one fifo_mem and owns all pointer, count and flag logic.

Test Plan:
- Use DWIDTH=8, AWIDTH=3, AFULL_TH=7 throughout.
- Reset then idle -> empty=1, full=0, count=0, overflow=0, underflow=0.
- Push 0x11..0x88 (8 cycles) -> count steps 1..8; almost_full=1 at count 7; full=1 at 8. Then pop 8 times -> rdata reads 0x11,0x22,...,0x88 in order; empty=1 at the end.
- Fill to 8, then push 0x99 -> overflow=1, count=8, contents unchanged. Then pulse clr_err -> overflow=0.
- Fill to 8, then push 0xAA with pop in the same cycle -> count=8, rdata becomes the 2nd entry. After 7 more pops, 0xAA is at the head (pointer wrap-around verified).
- On empty, push 0x5A with pop in the same cycle -> underflow=1, count=1, rdata=0x5A next cycle.
- Push 3 entries, then assert reset together with push -> next cycle count=0, empty=1, flags 0; the push in the reset cycle is ignored.
